// File: rtl/reaction_result_tx.sv
// Sends each new reaction-timer result as ASCII "d3 d2 d1 d0 CR LF" over a UART TX line.
// Optional `TX_PARITY_EN` inserts an even-parity bit after the data bits (8E1 frames).
module reaction_result_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs_en,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TMR_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef TX_PARITY_EN
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] STOP   = 3'd3;
    localparam logic [STATE_W-1:0] PARITY = 3'd4;
`else
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] START = 2'd1;
    localparam logic [STATE_W-1:0] DATA  = 2'd2;
    localparam logic [STATE_W-1:0] STOP  = 2'd3;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic               rs_en_q, rs_en_d;
    logic [15:0]        digits_q, digits_d;
    logic [7:0]         shift_q, shift_d;
    logic [CNT_W-1:0]   bit_tmr_q, bit_tmr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    function automatic logic [7:0] enc_digit(input logic [3:0] v);
        return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
    endfunction

    function automatic logic [7:0] byte_at(input logic [2:0] idx, input logic [15:0] dig);
        case (idx)
            3'd0:    return enc_digit(dig[15:12]);
            3'd1:    return enc_digit(dig[11:8]);
            3'd2:    return enc_digit(dig[7:4]);
            3'd3:    return enc_digit(dig[3:0]);
            3'd4:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign bit_end = (bit_tmr_q == TMR_MAX);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        rs_en_d    = rs_en;
        digits_d   = digits_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bit_tmr_d  = (state_q == IDLE || bit_end) ? '0 : bit_tmr_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rs_en && !rs_en_q) begin
                    state_d    = START;
                    digits_d   = {d3, d2, d1, d0};
                    shift_d    = enc_digit(d3);
                    byte_idx_d = 3'd0;
                    bit_cnt_d  = 3'd0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q < 3'd5) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = byte_at(byte_idx_q + 3'd1, digits_q);
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the upcoming state so the line changes exactly on bit boundaries
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef TX_PARITY_EN
            PARITY:  tx_d = ^byte_at(byte_idx_q, digits_q);
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!rst) begin
            state_q    <= IDLE;
            rs_en_q    <= 1'b0;
            digits_q   <= '0;
            shift_q    <= '0;
            bit_tmr_q  <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_en_q    <= rs_en_d;
            digits_q   <= digits_d;
            shift_q    <= shift_d;
            bit_tmr_q  <= bit_tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_reaction_result_tx.sv
// Scoreboard bench for reaction_result_tx: stimulus queues expected bytes, a UART monitor
// decodes tx and compares, a second monitor checks busy length and done pulses.
module tb_reaction_result_tx;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MSG_CYC = 6 * FB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rs_en = 1'b0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
    logic       tx, busy, done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int msg_exp = 0;
    logic [7:0] exp_q[$];

    reaction_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rs_en(rs_en),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART receiver: mid-bit sampling on falling clock edges
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       p;
        bit         aborted;
        int         bi;
        forever begin
            @(negedge clk);
            if (rst && tx == 1'b0) begin
                b = 8'h00;
                p = 1'b0;
                aborted = 1'b0;
                for (int c = 1; c < FB * CPB; c++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) begin
                        bi = c / CPB;
                        if (bi == 0)      check("start_bit", tx, 0);
                        else if (bi <= 8) b[bi-1] = tx;
                        else if (bi == FB - 1) check("stop_bit", tx, 1);
                        else              p = tx;
                    end
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", b, e);
`ifdef TX_PARITY_EN
                        check("parity_bit", p, ^e);
`endif
                    end
                end
            end
        end
    end

    // busy run length and done-at-fall monitor
    initial begin
        int len;
        bit ab;
        len = 0;
        ab = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (!rst) ab = 1'b1;
            if (busy === 1'b1) begin
                len++;
            end else begin
                if (len > 0 && !ab) begin
                    check("busy_len", len, MSG_CYC);
                    check("done_at_fall", done, 1);
                end
                len = 0;
                ab = 1'b0;
            end
        end
    end

    task automatic push_msg(input logic [7:0] b3, input logic [7:0] b2,
                            input logic [7:0] b1, input logic [7:0] b0);
        exp_q.push_back(b3);
        exp_q.push_back(b2);
        exp_q.push_back(b1);
        exp_q.push_back(b0);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        msg_exp++;
    endtask

    task automatic start_msg(input logic [3:0] a3, input logic [3:0] a2,
                             input logic [3:0] a1, input logic [3:0] a0,
                             input logic [7:0] b3, input logic [7:0] b2,
                             input logic [7:0] b1, input logic [7:0] b0);
        @(posedge clk);
        #1;
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
        push_msg(b3, b2, b1, b0);
        rs_en = 1'b1;
        @(negedge clk);
        check("idle_before_edge", busy, 0);
        @(negedge clk);
        check("busy_after_edge", busy, 1);
        check("tx_start_after_edge", tx, 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 3000), 1);
    endtask

    initial begin
        int n;
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // basic message 1,2,3,4
        start_msg(4'd1, 4'd2, 4'd3, 4'd4, 8'h31, 8'h32, 8'h33, 8'h34);
        repeat (5) @(negedge clk);
        rs_en = 1'b0;

        // new edge raised during the done cycle starts the invalid-digit message
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", (n < 1000), 1);
        d3 = 4'h0; d2 = 4'hA; d1 = 4'h9; d0 = 4'hF;
        push_msg(8'h30, 8'h3F, 8'h39, 8'h3F);
        rs_en = 1'b1;
        @(negedge clk);
        check("retrigger_in_done_cycle", busy, 1);
        wait_idle("invalid_digit_done");
        rs_en = 1'b0;
        repeat (5) @(negedge clk);

        // held rs_en plus re-pulse while busy: one message only
        start_msg(4'd4, 4'd2, 4'd0, 4'd7, 8'h34, 8'h32, 8'h30, 8'h37);
        repeat (49) @(negedge clk);
        rs_en = 1'b0;
        @(negedge clk);
        rs_en = 1'b1;
        repeat (950) @(negedge clk);
        rs_en = 1'b0;
        repeat (300) @(negedge clk);
        wait_idle("held_done");
        check("held_one_message", done_cnt, msg_exp);

        // snapshot integrity
        start_msg(4'd5, 4'd6, 4'd7, 4'd8, 8'h35, 8'h36, 8'h37, 8'h38);
        repeat (9) @(negedge clk);
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
        rs_en = 1'b0;
        wait_idle("snapshot_done");

        // reset during byte 2 data bits
        start_msg(4'd9, 4'd8, 4'd7, 4'd6, 8'h39, 8'h38, 8'h37, 8'h36);
        rs_en = 1'b0;
        repeat (2 * FB * CPB + 2 * CPB - 1) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        msg_exp--;
        repeat (3 * FB * CPB) @(negedge clk);
        check("abort_stays_idle", busy, 0);

        // full message after the abort
        start_msg(4'd9, 4'd8, 4'd7, 4'd6, 8'h39, 8'h38, 8'h37, 8'h36);
        rs_en = 1'b0;
        wait_idle("post_reset_done");
        repeat (10) @(negedge clk);

        check("done_count", done_cnt, msg_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
